// File: rtl/fifo_tx_sequencer.sv
// Read-side sequencer between the byte FIFO and the I2C byte transmitter.
// Pops exactly xfer_len bytes and streams them on valid/ready with tx_last on the final byte.
module fifo_tx_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int LEN_WIDTH     = 8,
    parameter int TIMEOUT       = 255,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  xfer_len,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic                  underrun,
    output logic [LEN_WIDTH-1:0]  bytes_left,
    input  logic                  fifo_read_empty,
    output logic                  fifo_read_enable,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  tx_last,
    input  logic                  tx_ready
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, PRESENT} state_t;

    localparam logic [TIMEOUT_WIDTH:0] TIMEOUT_VAL = (TIMEOUT_WIDTH+1)'(TIMEOUT);

    state_t                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    bytes_left_q, bytes_left_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic [TIMEOUT_WIDTH-1:0] starve_q, starve_d;
    logic                    done_q, done_d;
    logic                    aborted_q, aborted_d;
    logic                    underrun_q, underrun_d;
    logic                    pop;
    logic [TIMEOUT_WIDTH:0]  starve_inc;

    assign pop        = (state_q == FETCH) && !fifo_read_empty;
    assign starve_inc = {1'b0, starve_q} + 1'b1;

    always_comb begin
        state_d      = state_q;
        bytes_left_d = bytes_left_q;
        tx_data_d    = tx_data_q;
        starve_d     = starve_q;
        done_d       = 1'b0;
        aborted_d    = aborted_q;
        underrun_d   = underrun_q;

        // Abort overrides everything outside IDLE; any byte in flight is dropped.
        if (abort && state_q != IDLE) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
            done_d    = 1'b1;
            starve_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        aborted_d    = 1'b0;
                        underrun_d   = 1'b0;
                        starve_d     = '0;
                        bytes_left_d = xfer_len;
                        if (xfer_len != '0) state_d = FETCH;
                        else                done_d  = 1'b1;
                    end
                end
                FETCH: begin
                    if (pop) begin
                        state_d  = WAIT;
                        starve_d = '0;
                    end else if (starve_inc == TIMEOUT_VAL) begin
                        state_d    = IDLE;
                        underrun_d = 1'b1;
                        done_d     = 1'b1;
                        starve_d   = '0;
                    end else begin
                        starve_d = starve_inc[TIMEOUT_WIDTH-1:0];
                    end
                end
                WAIT: begin
                    tx_data_d = fifo_read_data;
                    state_d   = PRESENT;
                end
                PRESENT: begin
                    if (tx_ready) begin
                        if (bytes_left_q != '0) bytes_left_d = bytes_left_q - 1'b1;
                        if (bytes_left_q <= LEN_WIDTH'(1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bytes_left_q <= '0;
            tx_data_q    <= '0;
            starve_q     <= '0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bytes_left_q <= bytes_left_d;
            tx_data_q    <= tx_data_d;
            starve_q     <= starve_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            underrun_q   <= underrun_d;
        end
    end

    assign busy             = (state_q != IDLE);
    assign done             = done_q;
    assign aborted          = aborted_q;
    assign underrun         = underrun_q;
    assign bytes_left       = bytes_left_q;
    assign fifo_read_enable = pop;
    assign tx_data          = tx_data_q;
    assign tx_valid         = (state_q == PRESENT);
    assign tx_last          = (state_q == PRESENT) && (bytes_left_q == LEN_WIDTH'(1));

endmodule

// File: tb/tb_fifo_tx_sequencer.sv
// Scoreboard bench for fifo_tx_sequencer: FIFO model, expected beat/completion queues, negedge monitor.
module tb_fifo_tx_sequencer;
    localparam int DW = 8, LW = 8, TO = 16, TW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n = 1'b0, start = 1'b0, abort = 1'b0, tx_ready = 1'b0;
    logic [LW-1:0] xfer_len = '0;
    logic          busy, done, aborted, underrun, fifo_read_empty, fifo_read_enable;
    logic          tx_valid, tx_last;
    logic [LW-1:0] bytes_left;
    logic [DW-1:0] fifo_read_data = '0, tx_data;

    fifo_tx_sequencer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT(TO), .TIMEOUT_WIDTH(TW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .xfer_len(xfer_len), .abort(abort),
        .busy(busy), .done(done), .aborted(aborted), .underrun(underrun), .bytes_left(bytes_left),
        .fifo_read_empty(fifo_read_empty), .fifo_read_enable(fifo_read_enable),
        .fifo_read_data(fifo_read_data), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_last(tx_last), .tx_ready(tx_ready));

    typedef struct { logic [7:0] d; logic l; } beat_t;
    typedef struct { logic ab; logic ur; logic [7:0] bl; } cpl_t;
    beat_t exp_beats[$];
    cpl_t  exp_cpl[$];

    int checks = 0, errors = 0;
    int ncyc = 0, hs_cyc = 0, done_cyc = 0, n_done = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected or bound expired", name);
    endtask

    // FIFO model: byte store written only by stimulus, read pointer advanced by pops.
    logic [7:0] mem [0:1023];
    int push_cnt = 0, pop_cnt = 0;
    assign fifo_read_empty = (push_cnt == pop_cnt);
    always @(posedge clk)
        if (fifo_read_enable) begin
            fifo_read_data <= mem[pop_cnt[9:0]];
            pop_cnt        <= pop_cnt + 1;
        end

    // Ready driver: constant, random, or held low for hold_cnt cycles on hold_byte.
    logic       rdy_rand = 1'b0, rdy_const = 1'b1;
    logic [7:0] hold_byte = '0;
    int         hold_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (hold_cnt > 0 && tx_valid && tx_data == hold_byte) begin
            tx_ready = 1'b0;
            hold_cnt--;
        end else if (rdy_rand) tx_ready = 1'($urandom_range(0, 1));
        else                   tx_ready = rdy_const;
    end

    // Monitor: inputs are stable at the negedge, so valid&ready here is the next edge's handshake.
    logic       stall_pend = 1'b0, hold_l;
    logic [7:0] hold_d;
    always @(negedge clk) begin
        beat_t b;
        cpl_t  c;
        ncyc++;
        if (reset_n) begin
            if (fifo_read_enable && fifo_read_empty) fail("pop_on_empty");
            if (stall_pend && tx_valid) begin
                chk("hold_data", tx_data, hold_d);
                chk("hold_last", tx_last, hold_l);
            end
            stall_pend = tx_valid && !tx_ready;
            hold_d     = tx_data;
            hold_l     = tx_last;
            if (tx_valid && tx_ready) begin
                hs_cyc = ncyc;
                if (exp_beats.size() == 0) fail("unexpected_beat");
                else begin
                    b = exp_beats.pop_front();
                    chk("tx_data", tx_data, b.d);
                    chk("tx_last", tx_last, b.l);
                end
            end
            if (done) begin
                done_cyc = ncyc;
                n_done++;
                if (exp_cpl.size() == 0) fail("unexpected_done");
                else begin
                    c = exp_cpl.pop_front();
                    chk("cpl_aborted", aborted, c.ab);
                    chk("cpl_underrun", underrun, c.ur);
                    chk("cpl_bytes_left", bytes_left, c.bl);
                    chk("cpl_busy", busy, 0);
                end
            end
        end else stall_pend = 1'b0;
    end

    task automatic cyc(int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(logic [7:0] v);
        mem[push_cnt[9:0]] = v;
        push_cnt++;
    endtask

    task automatic go(int len);
        xfer_len = LW'(len);
        start    = 1'b1;
        cyc();
        start    = 1'b0;
    endtask

    task automatic wait_idle(string name);
        int t = 0;
        while ((exp_cpl.size() != 0 || busy) && t < 3000) begin cyc(); t++; end
        if (t >= 3000) fail(name);
    endtask

    task automatic wait_valid(string name);
        int t = 0;
        while (!tx_valid && t < 100) begin cyc(); t++; end
        if (t >= 100) fail(name);
    endtask

    task automatic expect_beat(logic [7:0] d, logic l);
        beat_t b;
        b.d = d; b.l = l;
        exp_beats.push_back(b);
    endtask

    task automatic expect_cpl(logic ab, logic ur, logic [7:0] bl);
        cpl_t c;
        c.ab = ab; c.ur = ur; c.bl = bl;
        exp_cpl.push_back(c);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_aborted"}, aborted, 0);
        chk({tag, "_underrun"}, underrun, 0);
        chk({tag, "_bytes_left"}, bytes_left, 0);
        chk({tag, "_rd_en"}, fifo_read_enable, 0);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_tx_last"}, tx_last, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
    endtask

    initial begin
        int p0, nd0, len, avail;
        logic [7:0] v;

        cyc(3);
        chk_all_zero("reset");
        reset_n = 1'b1;
        cyc(2);

        // Three bytes, ready always high.
        push(8'h0A); push(8'h0B); push(8'h0C);
        expect_beat(8'h0A, 0); expect_beat(8'h0B, 0); expect_beat(8'h0C, 1);
        expect_cpl(0, 0, 0);
        p0 = pop_cnt;
        go(3);
        wait_idle("t2_timeout");
        chk("t2_pops", pop_cnt - p0, 3);
        chk("t2_done_latency", done_cyc - hs_cyc, 1);

        // Same, with ready held low for 5 cycles on 0x0B.
        push(8'h0A); push(8'h0B); push(8'h0C);
        expect_beat(8'h0A, 0); expect_beat(8'h0B, 0); expect_beat(8'h0C, 1);
        expect_cpl(0, 0, 0);
        hold_byte = 8'h0B; hold_cnt = 5;
        p0 = pop_cnt;
        go(3);
        wait_idle("t3_timeout");
        chk("t3_pops", pop_cnt - p0, 3);

        // Starvation after one byte of two.
        push(8'h55);
        expect_beat(8'h55, 0);
        expect_cpl(0, 1, 1);
        go(2);
        wait_idle("t4_timeout");
        chk("t4_underrun_latency", done_cyc - hs_cyc, TO + 1);
        chk("t4_busy", busy, 0);
        chk("t4_bytes_left", bytes_left, 1);
        chk("t4_underrun", underrun, 1);

        // Abort while presenting.
        rdy_const = 1'b0;
        push(8'h66);
        expect_cpl(1, 0, 4);
        go(4);
        wait_valid("t5_valid_timeout");
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("t5_tx_valid", tx_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_aborted", aborted, 1);
        chk("t5_done", done, 1);
        wait_idle("t5_timeout");

        // Zero-length start clears aborted, completes next cycle, pops nothing.
        expect_cpl(0, 0, 0);
        p0 = pop_cnt;
        go(0);
        chk("t6_done", done, 1);
        chk("t6_aborted_cleared", aborted, 0);
        wait_idle("t6_timeout");
        chk("t6_pops", pop_cnt - p0, 0);

        // Abort in IDLE is ignored.
        nd0 = n_done;
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        cyc(3);
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_aborted", aborted, 0);
        chk("idle_abort_no_done", n_done - nd0, 0);

        // Start while busy is ignored.
        rdy_const = 1'b1;
        push(8'h21); push(8'h22);
        expect_beat(8'h21, 0); expect_beat(8'h22, 1);
        expect_cpl(0, 0, 0);
        go(2);
        cyc();
        xfer_len = 8'd7; start = 1'b1;
        cyc();
        start = 1'b0;
        wait_idle("busy_start_timeout");
        cyc(3);
        chk("busy_start_idle", busy, 0);

        // Reset mid-transfer: outputs clear at once, no done afterwards.
        rdy_const = 1'b0;
        push(8'h77);
        go(3);
        wait_valid("t1_valid_timeout");
        nd0 = n_done;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        cyc(2);
        reset_n = 1'b1;
        cyc(10);
        chk("midreset_no_done", n_done - nd0, 0);

        // Abort and start together in IDLE: start wins.
        rdy_const = 1'b1;
        push(8'h99);
        expect_beat(8'h99, 1);
        expect_cpl(0, 0, 0);
        xfer_len = 8'd1; start = 1'b1; abort = 1'b1;
        cyc();
        start = 1'b0; abort = 1'b0;
        wait_idle("start_abort_timeout");

        // Random transfers with random ready and occasional starvation.
        rdy_rand = 1'b1;
        for (int it = 0; it < 25; it++) begin
            len   = $urandom_range(1, 6);
            avail = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : len;
            for (int i = 0; i < avail; i++) begin
                v = 8'($urandom);
                push(v);
                expect_beat(v, (i == len - 1));
            end
            expect_cpl(0, (avail < len), 8'(len - avail));
            p0 = pop_cnt;
            go(len);
            wait_idle("rand_timeout");
            chk("rand_pops", pop_cnt - p0, avail);
        end
        rdy_rand = 1'b0;
        cyc(3);

        chk("beats_outstanding", exp_beats.size(), 0);
        chk("cpl_outstanding", exp_cpl.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
